// File: rtl/mmio_snapshot_master.sv
// mmio_snapshot_master
// Bus-master sequencer that walks the coprocessor window (address bit 12 = 1)
// in select order. For every select enabled in SEL_MASK it reads spec word 0
// and copies it into consecutive dmem words starting at DEST_BASE.
// Optional feature macro: SNAPSHOT_STAMP_EN appends one extra dmem word
// holding the frame number after the last select.
//
// Handshake: bus_req is held high in every state except IDLE. REQ waits for
// bus_gnt. In SCAN, RD, WR and STAMP nothing advances while bus_gnt is low,
// and m_wren is gated by bus_gnt, so a write only happens on a granted cycle.
// o_dbg_state exposes the FSM state for observation.
module mmio_snapshot_master #(
    parameter logic [31:0] SEL_MASK  = 32'h03033033,
    parameter logic [11:0] DEST_BASE = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [12:0] m_address,
    output logic [31:0] m_data,
    output logic        m_wren,
    input  logic [31:0] m_rdata,
    output logic [15:0] frame_count,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_SCAN  = 3'd2,
        S_RD    = 3'd3,
        S_WR    = 3'd4,
`ifdef SNAPSHOT_STAMP_EN
        S_STAMP = 3'd5,
`endif
        S_DONE  = 3'd6
    } state_t;

    // State entered after the final select has been handled.
`ifdef SNAPSHOT_STAMP_EN
    localparam state_t S_LAST = S_STAMP;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_ptr;
    logic [11:0] r_idx;
    logic [31:0] r_hold;
    logic [12:0] r_addr;
    logic [15:0] r_frame;

    logic        w_sel_en;
    logic        w_last;
    logic [11:0] w_dest;

    assign w_sel_en = SEL_MASK[r_ptr];
    assign w_last   = (r_ptr == 5'd31);
    // 12-bit sum: destination wraps modulo 4096.
    assign w_dest   = DEST_BASE + r_idx;

    assign m_address   = r_addr;
    assign frame_count = r_frame;
    assign o_dbg_state = r_state;

`ifdef SNAPSHOT_STAMP_EN
    // Stamp word carries the frame number this sweep is about to complete.
    assign m_data = (r_state == S_STAMP) ? {16'b0, r_frame + 16'd1} : r_hold;
`else
    assign m_data = r_hold;
`endif

    // State register; reset wins over everything including start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state outputs; granted cycles advance, others hold.
    always_comb begin
        w_next  = r_state;
        busy    = (r_state != S_IDLE);
        bus_req = (r_state != S_IDLE);
        done    = 1'b0;
        m_wren  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_REQ;
            end
            S_REQ: begin
                if (bus_gnt) w_next = S_SCAN;
            end
            S_SCAN: begin
                if (bus_gnt) begin
                    if (w_sel_en)    w_next = S_RD;
                    else if (w_last) w_next = S_LAST;
                end
            end
            S_RD: begin
                if (bus_gnt) w_next = S_WR;
            end
            S_WR: begin
                m_wren = bus_gnt;
                if (bus_gnt) w_next = w_last ? S_LAST : S_SCAN;
            end
`ifdef SNAPSHOT_STAMP_EN
            S_STAMP: begin
                m_wren = bus_gnt;
                if (bus_gnt) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: select pointer, slot index, read hold, bus address, frame count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ptr   <= 5'd0;
            r_idx   <= 12'd0;
            r_hold  <= 32'd0;
            r_addr  <= 13'd0;
            r_frame <= 16'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus_gnt) begin
                        r_ptr <= 5'd0;
                        r_idx <= 12'd0;
                    end
                end
                S_SCAN: begin
                    if (bus_gnt) begin
                        if (w_sel_en) begin
                            r_addr <= {1'b1, r_ptr, 5'b0, 2'b0};
                        end else if (!w_last) begin
                            r_ptr <= r_ptr + 5'd1;
                        end else begin
`ifdef SNAPSHOT_STAMP_EN
                            r_addr <= {1'b0, w_dest};
`endif
                        end
                    end
                end
                S_RD: begin
                    if (bus_gnt) begin
                        r_hold <= m_rdata;
                        r_addr <= {1'b0, w_dest};
                    end
                end
                S_WR: begin
                    if (bus_gnt) begin
                        r_idx <= r_idx + 12'd1;
                        if (!w_last) begin
                            r_ptr <= r_ptr + 5'd1;
                        end else begin
`ifdef SNAPSHOT_STAMP_EN
                            r_addr <= {1'b0, w_dest + 12'd1};
`endif
                        end
                    end
                end
                S_DONE: begin
                    r_frame <= r_frame + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_snapshot_master.sv
// Bench for mmio_snapshot_master: three instances (default parameters, empty
// mask, wrapping destination) share clock, reset and grant. A window model
// returns rd_tab[select] for window reads; expected dmem writes and sweep
// lengths are derived from the mask, base and table.
module tb_mmio_snapshot_master;

    localparam int NI = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        gnt   = 1'b1;
    logic        start_v [NI];
    logic        busy_v  [NI];
    logic        done_v  [NI];
    logic        req_v   [NI];
    logic        wren_v  [NI];
    logic [12:0] addr_v  [NI];
    logic [31:0] data_v  [NI];
    logic [31:0] rdata_v [NI];
    logic [15:0] fc_v    [NI];
    logic [2:0]  dbg_v   [NI];

    logic [31:0] rd_tab [32];
    logic [31:0] mask_of [NI];
    logic [11:0] base_of [NI];
    logic [15:0] fc_exp  [NI];

    logic [44:0] exp_q[$];
    logic [44:0] obs_q[$];

    int total = 0;
    int bad = 0;
    int wren_in_stall = 0;

    // clock / reset block
    always #5 clock = ~clock;

    mmio_snapshot_master u_def (
        .clock(clock), .reset(reset), .start(start_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .bus_req(req_v[0]), .bus_gnt(gnt), .m_address(addr_v[0]),
        .m_data(data_v[0]), .m_wren(wren_v[0]), .m_rdata(rdata_v[0]),
        .frame_count(fc_v[0]), .o_dbg_state(dbg_v[0])
    );

    mmio_snapshot_master #(.SEL_MASK(32'h0)) u_empty (
        .clock(clock), .reset(reset), .start(start_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .bus_req(req_v[1]), .bus_gnt(gnt), .m_address(addr_v[1]),
        .m_data(data_v[1]), .m_wren(wren_v[1]), .m_rdata(rdata_v[1]),
        .frame_count(fc_v[1]), .o_dbg_state(dbg_v[1])
    );

    mmio_snapshot_master #(.SEL_MASK(32'hF), .DEST_BASE(12'hFFE)) u_wrap (
        .clock(clock), .reset(reset), .start(start_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .bus_req(req_v[2]), .bus_gnt(gnt), .m_address(addr_v[2]),
        .m_data(data_v[2]), .m_wren(wren_v[2]), .m_rdata(rdata_v[2]),
        .frame_count(fc_v[2]), .o_dbg_state(dbg_v[2])
    );

    // Coprocessor window model: combinational return of the table entry.
    for (genvar g = 0; g < NI; g++) begin : g_win
        assign rdata_v[g] = addr_v[g][12] ? rd_tab[addr_v[g][11:7]] : 32'h0;
    end

    // Write monitor: log every dmem write, flag any write without grant.
    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            if (wren_v[i] === 1'b1) begin
                obs_q.push_back({addr_v[i], data_v[i]});
                if (gnt !== 1'b1) wren_in_stall++;
            end
        end
    end

    // One full sweep on instance w with scoreboard checks.
    // stall_rd: drop grant for 5 cycles on that RD occurrence (0 = none).
    // extra_start: pulse start at edge 10 and during the DONE cycle.
    // rnd_gnt: random grant pattern until done.
    task automatic run_sweep(input int w, input int stall_rd, input bit extra_start,
                             input bit rnd_gnt, input string tag);
        int          edge_n;
        int          done_edge;
        int          n_done;
        int          rd_n;
        int          stall_left;
        int          exp_edge;
        int          idx;
        int          n_cmp;
        bit          stalled;
        logic [2:0]  prev;
        logic [31:0] mask;
        logic [11:0] base;
        logic [15:0] fcx;
        mask = mask_of[w];
        base = base_of[w];
        fcx  = fc_exp[w];
        exp_q.delete();
        obs_q.delete();
        wren_in_stall = 0;
        idx = 0;
        for (int s = 0; s < 32; s++) begin
            if (mask[s]) begin
                exp_q.push_back({1'b0, base + idx[11:0], rd_tab[s]});
                idx++;
            end
        end
        exp_edge = 34 + 2 * $countones(mask) + ((stall_rd > 0) ? 5 : 0);
`ifdef SNAPSHOT_STAMP_EN
        exp_q.push_back({1'b0, base + idx[11:0], 16'h0, fcx + 16'd1});
        exp_edge = exp_edge + 1;
`endif
        done_edge = 0; n_done = 0; rd_n = 0; stall_left = 0; stalled = 0;
        prev = 3'd0;
        @(negedge clock);
        #1 start_v[w] = 1'b1;
        gnt = 1'b1;
        @(posedge clock);
        edge_n = 1;
        while (edge_n < 400) begin
            @(negedge clock);
            if (stall_left > 0) stall_left--;
            if (done_v[w] === 1'b1) begin
                n_done++;
                if (done_edge == 0) done_edge = edge_n;
            end
            if (stall_rd > 0 && dbg_v[w] == 3'd3 && prev != 3'd3) rd_n++;
            if (stall_rd > 0 && rd_n == stall_rd && !stalled) begin
                stall_left = 5;
                stalled = 1;
            end
            prev = dbg_v[w];
            #1;
            start_v[w] = extra_start && (edge_n == 10 || (done_edge != 0 && edge_n == done_edge));
            if (rnd_gnt && done_edge == 0) gnt = ($urandom_range(0, 3) != 0);
            else gnt = (stall_left == 0);
            if (done_edge != 0 && edge_n >= done_edge + 3) break;
            @(posedge clock);
            edge_n++;
        end
        gnt = 1'b1;
        start_v[w] = 1'b0;
        fc_exp[w] = fcx + 16'd1;

        total++;
        if (done_edge == 0) begin
            bad++;
            $display("FAIL %s done_timeout: no done within %0d edges", tag, edge_n);
        end
        total++;
        if (!rnd_gnt && done_edge != exp_edge) begin
            bad++;
            $display("FAIL %s done_edge: got %0d want %0d", tag, done_edge, exp_edge);
        end else if (rnd_gnt && done_edge < exp_edge) begin
            bad++;
            $display("FAIL %s done_edge: got %0d want >= %0d", tag, done_edge, exp_edge);
        end
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d want 1", tag, n_done);
        end
        total++;
        if (fc_v[w] !== fc_exp[w]) begin
            bad++;
            $display("FAIL %s frame_count: got %0d want %0d", tag, fc_v[w], fc_exp[w]);
        end
        total++;
        if ({busy_v[w], req_v[w]} !== 2'b00) begin
            bad++;
            $display("FAIL %s idle_after: busy/req got %b want 00", tag, {busy_v[w], req_v[w]});
        end
        total++;
        if (wren_in_stall != 0) begin
            bad++;
            $display("FAIL %s wren_no_gnt: got %0d writes want 0", tag, wren_in_stall);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s write_count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
        end
        n_cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s write[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         tag, i, obs_q[i][44:32], obs_q[i][31:0], exp_q[i][44:32], exp_q[i][31:0]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            total++;
            if ({busy_v[i], done_v[i], req_v[i], wren_v[i], addr_v[i], data_v[i], fc_v[i]} !== 66'h0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: busy=%b done=%b req=%b wren=%b addr=%h data=%h fc=%0d want all 0",
                         i, busy_v[i], done_v[i], req_v[i], wren_v[i], addr_v[i], data_v[i], fc_v[i]);
            end
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_default_sweep();
        run_sweep(0, 0, 1'b0, 1'b0, "default_sweep");
    endtask

    task automatic test_grant_stall();
        run_sweep(0, 3, 1'b0, 1'b0, "grant_stall");
    endtask

    task automatic test_start_during();
        run_sweep(0, 0, 1'b1, 1'b0, "start_during");
    endtask

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        @(negedge clock);
        #1 start_v[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1 start_v[0] = 1'b0;
        for (int e = 2; e < 20; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (done_v[0] === 1'b1) n_done++;
        end
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        if (done_v[0] === 1'b1) n_done++;
        total++;
        if ({busy_v[0], done_v[0], req_v[0], wren_v[0], addr_v[0], data_v[0]} !== 50'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b req=%b wren=%b addr=%h data=%h want all 0",
                     busy_v[0], done_v[0], req_v[0], wren_v[0], addr_v[0], data_v[0]);
        end
        total++;
        if (fc_v[0] !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_frame_count: got %0d want 0", fc_v[0]);
        end
        total++;
        if (n_done != 0) begin
            bad++;
            $display("FAIL reset_mid_done: got %0d done pulses want 0", n_done);
        end
        for (int i = 0; i < NI; i++) fc_exp[i] = 16'h0;
        #1 reset = 1'b1;
        run_sweep(0, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_empty_mask();
        run_sweep(1, 0, 1'b0, 1'b0, "empty_mask");
    endtask

    task automatic test_addr_wrap();
        run_sweep(2, 0, 1'b0, 1'b0, "addr_wrap");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 32; s++) rd_tab[s] = $urandom;
            run_sweep(0, 0, 1'b0, 1'b1, "random_default");
            run_sweep(2, 0, 1'b0, 1'b1, "random_wrap");
        end
    endtask

    initial begin
        logic [4:0] sv;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            fc_exp[i]  = 16'h0;
        end
        mask_of[0] = 32'h03033033; base_of[0] = 12'hF00;
        mask_of[1] = 32'h00000000; base_of[1] = 12'hF00;
        mask_of[2] = 32'h0000000F; base_of[2] = 12'hFFE;
        for (int s = 0; s < 32; s++) begin
            sv = s[4:0];
            rd_tab[s] = {sv, 27'h0};
        end
        test_reset();
        test_default_sweep();
        test_grant_stall();
        test_start_during();
        test_reset_mid();
        test_empty_mask();
        test_addr_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
